md_sched: RTL

- Sequencing controller for the pipeline's multiply/divide resource: owns the HI/LO registers and the multi-cycle busy window.
- Generates xstall, which freezes PC and the F/D register while a D-stage mult/div-class instruction cannot issue.
- Sits in E beside the ALU and is driven by the decoded xaluop of the D and E stages.
- Its xaluout feeds the E-stage result mux.

---
 rtl/md_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// Multiply/divide sequencer: owns HI/LO, runs a fixed-latency busy window per
// operation, and stalls D-stage md instructions while the unit is occupied.
module md_sched #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  xaluop_d,
   input  logic [3:0]  xaluop_e,
   input  logic [31:0] numa,
   input  logic [31:0] numb,
   output logic        xstall,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] xaluout
);

   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMfhi  = 4'd5;
   localparam logic [3:0] OpMflo  = 4'd6;
   localparam logic [3:0] OpMthi  = 4'd7;
   localparam logic [3:0] OpMtlo  = 4'd8;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

   logic        is_arith_e, is_md_d, start;
   logic [63:0] ext_a, ext_b, prod_s, prod_u;
   logic [31:0] abs_a, abs_b, mag_q, mag_r, sdiv_q, sdiv_r, udiv_q, udiv_r;
   logic [31:0] calc_hi, calc_lo;

   assign is_arith_e = (xaluop_e >= OpMult) && (xaluop_e <= OpDivu);
   assign is_md_d    = (xaluop_d >= OpMult) && (xaluop_d <= OpMtlo);
   assign start      = (state_q == StIdle) && is_arith_e;

   // Sign-extended 64-bit product truncated to 64 bits equals the signed product.
   assign ext_a  = {{32{numa[31]}}, numa};
   assign ext_b  = {{32{numb[31]}}, numb};
   assign prod_s = ext_a * ext_b;
   assign prod_u = {32'd0, numa} * {32'd0, numb};

   // Signed divide via magnitudes; quotient truncates toward zero, remainder follows dividend.
   assign abs_a  = numa[31] ? -numa : numa;
   assign abs_b  = numb[31] ? -numb : numb;
   assign mag_q  = abs_a / abs_b;
   assign mag_r  = abs_a % abs_b;
   assign sdiv_q = (numa[31] ^ numb[31]) ? -mag_q : mag_q;
   assign sdiv_r = numa[31] ? -mag_r : mag_r;
   assign udiv_q = numa / numb;
   assign udiv_r = numa % numb;

   always_comb begin
      calc_hi = 32'd0;
      calc_lo = 32'd0;
      case (xaluop_e)
         OpMult: begin
            calc_hi = prod_s[63:32];
            calc_lo = prod_s[31:0];
         end
         OpMultu: begin
            calc_hi = prod_u[63:32];
            calc_lo = prod_u[31:0];
         end
         OpDiv: begin
            if (numb == 32'd0) begin
               calc_hi = numa;
               calc_lo = 32'hFFFF_FFFF;
            end else begin
               calc_hi = sdiv_r;
               calc_lo = sdiv_q;
            end
         end
         OpDivu: begin
            if (numb == 32'd0) begin
               calc_hi = numa;
               calc_lo = 32'hFFFF_FFFF;
            end else begin
               calc_hi = udiv_r;
               calc_lo = udiv_q;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               pend_hi_d = calc_hi;
               pend_lo_d = calc_lo;
               cnt_d     = (xaluop_e <= OpMultu) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
               state_d   = StRun;
            end else if (xaluop_e == OpMthi) begin
               hi_d = numa;
            end else if (xaluop_e == OpMtlo) begin
               lo_d = numa;
            end
         end
         StRun: begin
            if (cnt_q <= 4'd1) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               cnt_d   = 4'd0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d == StRun);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         busy_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

   assign busy   = busy_q;
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign xstall = is_md_d && (busy_q || start);

   always_comb begin
      xaluout = 32'd0;
      if (xaluop_e == OpMfhi) xaluout = hi_q;
      else if (xaluop_e == OpMflo) xaluout = lo_q;
   end

endmodule
